// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Arbitrates N_REQ read requesters onto one synchronous ROM port (1-cycle
//   read latency). Requesters are served round-robin. A requester may hold
//   the port for a burst of up to MAX_BURST accesses by raising lock. Read
//   data returns two cycles after the accepting edge, tagged by a one-hot
//   rvalid.
//
// Ports
//   pclk      : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   req       : per-requester read request
//   lock      : per-requester burst lock (only meaningful with req)
//   addr      : packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt       : one-hot combinational grant; accepted when req[i] & gnt[i]
//   rom_addr  : registered ROM address
//   rom_data  : ROM read data
//   rdata     : registered copy of rom_data, broadcast to all requesters
//   rvalid    : one-hot owner tag for rdata
module ram_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 12,
  parameter int MAX_BURST = 8
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [DATA_W-1:0]       rdata,
  output logic [N_REQ-1:0]        rvalid
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ROUND_ROBIN = 1'b0,
    LOCKED      = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [PTR_W-1:0]   owner, owner_n;
  logic [CNT_W-1:0]   burst_cnt, cnt_n;

  logic [N_REQ-1:0]   gnt_rr;
  logic [PTR_W-1:0]   idx;
  logic               found;
  logic               accept;
  logic [PTR_W-1:0]   win;
  logic [ADDR_W-1:0]  win_addr;

  logic [N_REQ-1:0]   vld_p0;
  logic [N_REQ-1:0]   vld_p1;

  // Successor of a requester index, wrapping at N_REQ.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(N_REQ - 1)) return '0;
    else                        return p + 1'b1;
  endfunction

  // Round-robin search: first asserted req at or above ptr, wrapping.
  always_comb begin
    gnt_rr = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        gnt_rr[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // While locked only the owner can be granted; gnt is forced low in reset.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (state == LOCKED) gnt[owner] = req[owner];
      else                 gnt        = gnt_rr;
    end
  end

  // gnt is only ever high where req is high, so any gnt bit is an acceptance.
  always_comb begin
    accept   = |gnt;
    win      = '0;
    win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win      = PTR_W'(i);
        win_addr = addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = burst_cnt;
    case (state)
      ROUND_ROBIN: begin
        if (accept) begin
          // A burst limit of one leaves nothing to lock for.
          if (lock[win] && (MAX_BURST > 1)) begin
            state_n = LOCKED;
            owner_n = win;
            cnt_n   = CNT_W'(1);
          end else begin
            ptr_n = ptr_inc(win);
          end
        end
      end
      LOCKED: begin
        if (!req[owner]) begin
          state_n = ROUND_ROBIN;
          ptr_n   = ptr_inc(owner);
          cnt_n   = '0;
        end else if (!lock[owner] || (int'(burst_cnt) + 1 >= MAX_BURST)) begin
          // Final access of the burst; ptr moves past the owner so a forced
          // release reaches every other pending requester before the owner.
          state_n = ROUND_ROBIN;
          ptr_n   = ptr_inc(owner);
          cnt_n   = '0;
        end else begin
          cnt_n = burst_cnt + 1'b1;
        end
      end
      default: state_n = ROUND_ROBIN;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state     <= ROUND_ROBIN;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      owner     <= owner_n;
      burst_cnt <= cnt_n;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      vld_p0   <= '0;
      vld_p1   <= '0;
      rvalid   <= '0;
      rdata    <= '0;
    end else begin
      // p0: accepting edge, address launched to the ROM
      if (accept) rom_addr <= win_addr;
      vld_p0 <= gnt;
      // p1: ROM registers the address, rom_data valid after this edge
      vld_p1 <= vld_p0;
      // output: capture ROM data alongside its owner tag
      rvalid <= vld_p1;
      rdata  <= rom_data;
    end
  end

endmodule
